// File: rtl/bist_pkg.sv
// Shared types and constants for the full-adder BIST output response analyser.
package bist_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPACT = 2'd1,
        CHECK   = 2'd2,
        DONE    = 2'd3
    } state_e;

    localparam int         CNT_W    = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    localparam logic [3:0] DEF_POLY = 4'h3;
    localparam logic [3:0] DEF_SEED = 4'h0;

endpackage

// File: rtl/misr_core.sv
// Galois-style multiple-input signature register: loads a seed or folds a
// 2-bit response (carry, sum) into the low bits on each shift.
module misr_core
    import bist_pkg::*;
#(
    parameter int               SIG_W = 4,
    parameter logic [SIG_W-1:0] POLY  = SIG_W'(DEF_POLY),
    parameter logic [SIG_W-1:0] SEED  = SIG_W'(DEF_SEED)
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             load,
    input  logic             shift_en,
    input  logic [1:0]       data_in,
    output logic [SIG_W-1:0] sig
);

    logic [SIG_W-1:0] sig_q;
    logic [SIG_W-1:0] sig_d;
    logic [SIG_W-1:0] shifted;
    logic             fb;

    assign fb = sig_q[SIG_W-1];

    // Bits 0 and 1 also absorb the response inputs; the rest only shift.
    genvar gi;
    generate
        for (gi = 0; gi < SIG_W; gi++) begin : g_bit
            if (gi == 0) begin : g_lsb
                assign shifted[gi] = (fb & POLY[gi]) ^ data_in[0];
            end else if (gi == 1) begin : g_in1
                assign shifted[gi] = sig_q[gi-1] ^ (fb & POLY[gi]) ^ data_in[1];
            end else begin : g_hi
                assign shifted[gi] = sig_q[gi-1] ^ (fb & POLY[gi]);
            end
        end
    endgenerate

    always_comb begin
        sig_d = sig_q;
        if (load) begin
            sig_d = SEED;
        end else if (shift_en) begin
            sig_d = shifted;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            sig_q <= SEED;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/bist_ora_misr.sv
// Output response analyser: compacts CUT responses into a MISR, counts them,
// and issues a registered pass/fail verdict once the pattern generator finishes.
module bist_ora_misr
    import bist_pkg::*;
#(
    parameter int               SIG_W        = 4,
    parameter logic [SIG_W-1:0] POLY         = SIG_W'(DEF_POLY),
    parameter logic [SIG_W-1:0] SEED         = SIG_W'(DEF_SEED),
    parameter logic [SIG_W-1:0] GOLDEN       = '0,
    parameter logic [CNT_W-1:0] EXP_PATTERNS = 8'd7
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             resp_valid,
    input  logic             cut_sum,
    input  logic             cut_cout,
    input  logic             tpg_complete,
    output logic [SIG_W-1:0] signature,
    output logic [CNT_W-1:0] pattern_count,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             fail
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic             fail_q, fail_d;
    logic             misr_load;
    logic             misr_shift;
    logic             verdict_ok;
    logic [SIG_W-1:0] sig;

    misr_core #(
        .SIG_W (SIG_W),
        .POLY  (POLY),
        .SEED  (SEED)
    ) u_misr (
        .clk      (clock),
        .srst     (reset),
        .load     (misr_load),
        .shift_en (misr_shift),
        .data_in  ({cut_cout, cut_sum}),
        .sig      (sig)
    );

    assign verdict_ok = (sig == GOLDEN) && (cnt_q == EXP_PATTERNS) && !ovf_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        done_d     = done_q;
        pass_d     = pass_q;
        fail_d     = fail_q;
        misr_load  = 1'b0;
        misr_shift = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    misr_load = 1'b1;
                    cnt_d     = '0;
                    ovf_d     = 1'b0;
                    state_d   = COMPACT;
                end
            end
            COMPACT: begin
                if (resp_valid) begin
                    misr_shift = 1'b1;
                    // Saturate rather than wrap so a runaway generator can never alias a good count.
                    if (cnt_q == CNT_MAX) begin
                        ovf_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                if (tpg_complete) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                done_d  = 1'b1;
                pass_d  = verdict_ok;
                fail_d  = !verdict_ok;
                state_d = DONE;
            end
            DONE: begin
                if (start) begin
                    done_d    = 1'b0;
                    pass_d    = 1'b0;
                    fail_d    = 1'b0;
                    misr_load = 1'b1;
                    cnt_d     = '0;
                    ovf_d     = 1'b0;
                    state_d   = COMPACT;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == COMPACT) || (state_d == CHECK);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
        end
    end

    assign signature     = sig;
    assign pattern_count = cnt_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign fail          = fail_q;

endmodule

// File: tb/tb_bist_ora_misr.sv
// Randomised self-checking bench for bist_ora_misr; two instances with different
// golden values share the same stimulus and are checked against one reference model.
module tb_bist_ora_misr;

    logic       clk = 1'b0;
    logic       reset, start, resp_valid, cut_sum, cut_cout, tpg_complete;
    logic [3:0] a_sig, b_sig;
    logic [7:0] a_cnt, b_cnt;
    logic       a_busy, a_done, a_pass, a_fail;
    logic       b_busy, b_done, b_pass, b_fail;

    int n_checks = 0;
    int n_errors = 0;

    logic [3:0] m_sig;
    int         m_n;
    logic [1:0] resp_q[$];

    always #5 clk = ~clk;

    // Instance A: default golden (0) and expected count (7).
    bist_ora_misr dut_a (
        .clock(clk), .reset(reset), .start(start), .resp_valid(resp_valid),
        .cut_sum(cut_sum), .cut_cout(cut_cout), .tpg_complete(tpg_complete),
        .signature(a_sig), .pattern_count(a_cnt), .busy(a_busy),
        .done(a_done), .pass(a_pass), .fail(a_fail)
    );

    bist_ora_misr #(.GOLDEN(4'h4), .EXP_PATTERNS(8'd3)) dut_b (
        .clock(clk), .reset(reset), .start(start), .resp_valid(resp_valid),
        .cut_sum(cut_sum), .cut_cout(cut_cout), .tpg_complete(tpg_complete),
        .signature(b_sig), .pattern_count(b_cnt), .busy(b_busy),
        .done(b_done), .pass(b_pass), .fail(b_fail)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Polynomial division step x^4+x+1 written as plain integer arithmetic.
    function automatic logic [3:0] misr_step(input logic [3:0] s, input logic [1:0] r);
        int v;
        v = (int'(s) * 2) % 16;
        if (s >= 4'd8) v = v ^ 3;
        v = v ^ int'(r);
        return v[3:0];
    endfunction

    function automatic int sat_cnt();
        return (m_n > 255) ? 255 : m_n;
    endfunction

    task automatic check_all(input string tag, input bit busy_e, input bit done_e);
        bit pa, pb;
        pa = done_e && (m_sig == 4'h0) && (m_n == 7);
        pb = done_e && (m_sig == 4'h4) && (m_n == 3);
        check_val({tag, "/a_sig"},  32'(a_sig),  32'(m_sig));
        check_val({tag, "/b_sig"},  32'(b_sig),  32'(m_sig));
        check_val({tag, "/a_cnt"},  32'(a_cnt),  32'(sat_cnt()));
        check_val({tag, "/b_cnt"},  32'(b_cnt),  32'(sat_cnt()));
        check_val({tag, "/a_busy"}, 32'(a_busy), 32'(busy_e));
        check_val({tag, "/b_busy"}, 32'(b_busy), 32'(busy_e));
        check_val({tag, "/a_done"}, 32'(a_done), 32'(done_e));
        check_val({tag, "/b_done"}, 32'(b_done), 32'(done_e));
        check_val({tag, "/a_pass"}, 32'(a_pass), 32'(pa));
        check_val({tag, "/a_fail"}, 32'(a_fail), 32'(done_e && !pa));
        check_val({tag, "/b_pass"}, 32'(b_pass), 32'(pb));
        check_val({tag, "/b_fail"}, 32'(b_fail), 32'(done_e && !pb));
    endtask

    task automatic idle_inputs();
        start = 0; resp_valid = 0; tpg_complete = 0; cut_sum = 0; cut_cout = 0;
    endtask

    // Full compaction run over resp_q; called at a negedge with the DUTs in IDLE or DONE.
    task automatic run(input string name, input bit merge, input bit gaps);
        start = 1;
        @(negedge clk);
        start = 0;
        m_sig = 4'h0;
        m_n   = 0;
        check_all({name, "/start"}, 1, 0);
        foreach (resp_q[i]) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                cut_sum = 1'($urandom); cut_cout = 1'($urandom); start = 1'($urandom);
                @(negedge clk);
                start = 0;
                check_all({name, "/gap"}, 1, 0);
            end
            resp_valid   = 1;
            cut_sum      = resp_q[i][0];
            cut_cout     = resp_q[i][1];
            tpg_complete = merge && (i == resp_q.size() - 1);
            @(negedge clk);
            idle_inputs();
            m_sig = misr_step(m_sig, resp_q[i]);
            m_n++;
            check_all({name, "/resp"}, 1, 0);
        end
        if (!merge) begin
            tpg_complete = 1;
            @(negedge clk);
            tpg_complete = 0;
            check_all({name, "/complete"}, 1, 0);
        end
        // CHECK cycle: responses presented now must be ignored.
        resp_valid = 1; cut_sum = 1'($urandom); cut_cout = 1'($urandom);
        tpg_complete = 1'($urandom);
        @(negedge clk);
        idle_inputs();
        check_all({name, "/verdict"}, 0, 1);
        for (int h = 0; h < 2; h++) begin
            resp_valid = 1; cut_sum = 1; tpg_complete = 1'($urandom);
            @(negedge clk);
            idle_inputs();
            check_all({name, "/hold"}, 0, 1);
        end
        $display("run %s: responses=%0d sig=%h cnt=%0d pass_a=%0b pass_b=%0b",
                 name, m_n, a_sig, a_cnt, a_pass, b_pass);
    endtask

    initial begin
        logic [1:0] r;
        reset = 1;
        idle_inputs();
        for (int c = 0; c < 3; c++) begin
            start = 1'(c); resp_valid = 1'(c + 1);
            @(negedge clk);
        end
        idle_inputs();
        m_sig = 4'h0; m_n = 0;
        check_all("reset", 0, 0);
        reset = 0;
        $display("reset: sig=%h cnt=%0d", a_sig, a_cnt);

        // Responses ignored in IDLE.
        resp_valid = 1; cut_sum = 1; tpg_complete = 1;
        @(negedge clk);
        idle_inputs();
        check_all("idle_ignore", 0, 0);

        resp_q = '{2'b01, 2'b00, 2'b00};
        run("basic3", 0, 0);
        check_val("basic3/const_sig", 32'(b_sig), 32'h4);

        resp_q = '{2'b11, 2'b00, 2'b00, 2'b00, 2'b00};
        run("feedback", 0, 0);
        check_val("feedback/const_sig", 32'(a_sig), 32'h5);

        resp_q = '{2'b01, 2'b00, 2'b00};
        run("merged", 1, 0);

        resp_q = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        run("golden7", 0, 1);
        check_val("golden7/const_pass", 32'(a_pass), 32'h1);

        // Reset in the middle of a run.
        start = 1;
        @(negedge clk);
        start = 0;
        for (int i = 0; i < 2; i++) begin
            resp_valid = 1; cut_sum = 1; cut_cout = 1'(i);
            @(negedge clk);
        end
        reset = 1; resp_valid = 1; cut_sum = 1;
        @(negedge clk);
        reset = 0;
        m_sig = 4'h0; m_n = 0;
        check_all("mid_reset", 0, 0);
        for (int i = 0; i < 3; i++) begin
            resp_valid = 1; cut_sum = 1; cut_cout = 1; tpg_complete = 1'(i);
            @(negedge clk);
            check_all("post_reset_ignore", 0, 0);
        end
        idle_inputs();
        $display("mid_reset: sig=%h cnt=%0d busy=%0b", a_sig, a_cnt, a_busy);

        for (int k = 0; k < 8; k++) begin
            int len;
            bit mg;
            len = $urandom_range(0, 12);
            mg  = (len > 0) ? 1'($urandom) : 1'b0;
            resp_q.delete();
            for (int j = 0; j < len; j++) begin
                r = 2'($urandom);
                resp_q.push_back(r);
            end
            run($sformatf("rand%0d", k), mg, 1);
        end

        resp_q.delete();
        for (int j = 0; j < 260; j++) begin
            r = 2'($urandom);
            resp_q.push_back(r);
        end
        run("overflow", 0, 0);

        // Reset out of DONE clears the verdict.
        reset = 1;
        @(negedge clk);
        reset = 0;
        m_sig = 4'h0; m_n = 0;
        check_all("done_reset", 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/bist_ora_misr.md
# bist_ora_misr

Output response analyser for the full-adder BIST chain. Sits directly downstream of the 3-bit LFSR pattern generator and the full-adder CUT. Compacts each CUT response (sum, carry-out) into a multiple-input signature register (MISR) and counts the responses. When the generator signals completion, compares the signature and the count against golden values and raises a registered pass/fail verdict.

## Interface
- SIG_W, 4: MISR width; must be ≥ 2.
- POLY, 4'h3: Galois feedback mask XORed in when the MSB shifts out (x^4+x+1).
- SEED, 4'h0: MISR value after reset and after each start.
- GOLDEN, 4'h0: expected final signature.
- EXP_PATTERNS, 8'd7: expected response count (full 3-bit LFSR cycle).
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  single-cycle pulse; begins a compaction run.
- resp_valid  in  1  cut_sum and cut_cout hold a valid response this cycle.
- cut_sum  in  1  CUT sum output.
- cut_cout  in  1  CUT carry output.
- tpg_complete  in  1  pattern generator has finished; level or pulse.
- signature  out  SIG_W  current MISR contents.
- pattern_count  out  8  responses compacted in this run.
- busy  out  1  high in COMPACT and CHECK.
- done  out  1  verdict valid; held until the next start or reset.
- pass  out  1  signature == GOLDEN and pattern_count == EXP_PATTERNS and no overflow.
- fail  out  1  complement of pass while done; 0 otherwise.

## Operation
- Reset values: state IDLE, signature = SEED, pattern_count = 0, busy/done/pass/fail = 0.
- MISR update, per accepted response: next = {sig[SIG_W-2:0],0} ^ (sig[SIG_W-1] ? POLY : 0) ^ {0…, cut_cout, cut_sum}.
- IDLE: ignore resp_valid and tpg_complete. On start, load SEED, clear the count, and go to COMPACT.
- COMPACT: on each resp_valid, update the MISR and increment the count.
  - The count saturates at 255 and sets an internal overflow flag, which forces fail.
  - When tpg_complete is sampled high, go to CHECK. A response with resp_valid in the same cycle is still compacted.
  - start is ignored in this state.
- CHECK: exactly one cycle. Register pass/fail from the compare, then go to DONE. resp_valid is ignored.
- DONE: hold signature, count and verdict. On start, clear done/pass/fail, load SEED, clear the count, and go to COMPACT. All other inputs are ignored.
- Reset in any state returns everything to its reset values on that edge. A run in progress is discarded.

## Timing
- MISR and count reflect a response one edge after it is sampled.
- tpg_complete sampled at edge k gives CHECK after edge k, and done/pass/fail high after edge k+1.
- busy rises on the edge that samples start and falls on the edge that sets done.
- pass and fail are never both high. Both are 0 whenever done = 0.
- Outputs are registered only; there is no combinational input-to-output path.

## Structure
- Shared package bist_pkg holds:
  - the state enum (IDLE, COMPACT, CHECK, DONE);
  - the default POLY/SEED constants;
  - the count width localparam.
- One sub-module, misr_core: the parameterised SIG_W register with load-seed and shift-enable. The FSM, counter and compare stay in bist_ora_misr.

## Test plan
- Reset held for 3 cycles, with start and resp_valid toggling → signature 4'h0, count 0, busy/done/pass/fail all 0.
- start; 3 responses (sum,cout) = (1,0),(0,0),(0,0); tpg_complete; GOLDEN=4'h4, EXP=3 → signature 0001→0010→0100, done and pass high 2 edges after complete, fail 0.
- Same stimulus with EXP_PATTERNS=7 → signature 4'h4, pattern_count 3, done=1, pass=0, fail=1.
- Feedback: responses (1,1) then 4×(0,0) → signature 0011, 0110, 1100, 1011, 0101. GOLDEN=4'h5, EXP=5 → pass.
- resp_valid and tpg_complete high in the same cycle as the 3rd response → count 3, that response included in the signature; a later start restarts cleanly from SEED.
- Reset asserted mid-COMPACT after 2 responses → next cycle IDLE, signature SEED, count 0. Subsequent resp_valid is ignored until start.
